// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a sliding window,
// emitting every fully interior window of a raster-ordered 8-bit frame.
module window_3x3_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pixel_in,
   input  logic        pixel_in_valid,
   input  logic        sof,
   output logic [71:0] pixels_out,
   output logic        pixels_out_valid,
   output logic        frame_done
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(2);
   localparam logic [RW-1:0] ROW_FIRST = RW'(2);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          accept;

   logic [7:0] line_a [IMG_WIDTH];
   logic [7:0] line_b [IMG_WIDTH];
   logic [7:0] a_rd;
   logic [7:0] b_rd;

   logic [7:0] win_p1 [3][3];
   logic       vld_p1;
   logic       done_p1;

   // sof relocates the accepted pixel to (0,0) regardless of the running counters
   always_comb begin
      accept  = pixel_in_valid && !rst;
      cur_col = sof ? '0 : col;
      cur_row = sof ? '0 : row;
   end

   assign a_rd = line_a[cur_col];
   assign b_rd = line_b[cur_col];

   // Line buffers are plain RAM: no reset, one write per accepted pixel
   always_ff @(posedge clk) begin
      if (accept) begin
         line_b[cur_col] <= a_rd;
         line_a[cur_col] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (pixel_in_valid) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   // ---- stage p1: window shift and output qualification ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win_p1[i][j] <= '0;
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
      end else begin
         vld_p1  <= pixel_in_valid && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
         done_p1 <= pixel_in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
         if (pixel_in_valid) begin
            for (int i = 0; i < 3; i++) begin
               win_p1[i][0] <= win_p1[i][1];
               win_p1[i][1] <= win_p1[i][2];
            end
            win_p1[0][2] <= b_rd;
            win_p1[1][2] <= a_rd;
            win_p1[2][2] <= pixel_in;
         end
      end
   end

   always_comb begin
      pixels_out = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            pixels_out[71 - 8*(3*i + j) -: 8] = win_p1[i][j];
   end

   assign pixels_out_valid = vld_p1;
   assign frame_done       = done_p1;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: directed frames plus randomized gaps/values, checked
// against a model that keeps the whole current frame as a 2-D image.
module tb_window_3x3_gen;

   localparam int W = 5;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pixel_in;
   logic        pixel_in_valid;
   logic        sof;
   logic [71:0] pixels_out;
   logic        pixels_out_valid;
   logic        frame_done;

   window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk              (clk),
      .rst              (rst),
      .pixel_in         (pixel_in),
      .pixel_in_valid   (pixel_in_valid),
      .sof              (sof),
      .pixels_out       (pixels_out),
      .pixels_out_valid (pixels_out_valid),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  img [H][W];
   int          mr = 0;
   int          mc = 0;
   int          win_cnt;
   int          done_cnt;
   logic [71:0] first_win;
   logic [71:0] last_win;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      win_cnt  = 0;
      done_cnt = 0;
      first_win = '0;
      last_win  = '0;
   endtask

   // One clock: drive inputs, advance the image model, then check outputs after the edge
   task automatic step(input logic v, input logic s, input logic [7:0] p, input logic r_in);
      logic        exp_valid;
      logic        exp_done;
      logic [71:0] exp_win;
      pixel_in_valid = v;
      sof            = s;
      pixel_in       = p;
      rst            = r_in;
      @(posedge clk);
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      exp_win   = '0;
      if (r_in) begin
         mr = 0;
         mc = 0;
      end else if (v) begin
         if (s) begin
            mr = 0;
            mc = 0;
         end
         img[mr][mc] = p;
         exp_valid = (mr >= 2) && (mc >= 2);
         exp_done  = (mr == H-1) && (mc == W-1);
         if (exp_valid)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  exp_win[71 - 8*(3*i + j) -: 8] = img[mr-2+i][mc-2+j];
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end
      end
      #1;
      chk("valid", 72'(pixels_out_valid), 72'(exp_valid));
      chk("frame_done", 72'(frame_done), 72'(exp_done));
      if (exp_valid) chk("window", pixels_out, exp_win);
      if (r_in) chk("reset_pixels_out", pixels_out, 72'h0);
      if (pixels_out_valid) begin
         if (win_cnt == 0) first_win = pixels_out;
         last_win = pixels_out;
         win_cnt++;
      end
      if (frame_done) done_cnt++;
   endtask

   // Sends the first n pixels of a frame in raster order, optionally with random idle gaps
   task automatic send_pixels(input int base, input int n, input bit use_sof,
                              input bit gaps, input bit rnd);
      logic [7:0] val;
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            int g = $urandom_range(0, 2);
            for (int q = 0; q < g; q++)
               step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
         end
         val = rnd ? 8'($urandom) : 8'(base + 16*(k / W) + (k % W));
         step(1'b1, use_sof && (k == 0), val, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      pixel_in_valid = 1'b0;
      sof = 1'b0;
      pixel_in = '0;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Clean frame with sof
      clear_counts();
      send_pixels(0, W*H, 1'b1, 1'b0, 1'b0);
      chk("f1_first", first_win, 72'h00_01_02_10_11_12_20_21_22);
      chk("f1_last", last_win, 72'h12_13_14_22_23_24_32_33_34);
      chk("f1_count", 72'(win_cnt), 72'd6);
      chk("f1_done", 72'(done_cnt), 72'd1);

      // Same frame with random idle gaps, including at row boundaries
      clear_counts();
      send_pixels(0, W*H, 1'b1, 1'b1, 1'b0);
      chk("gap_first", first_win, 72'h00_01_02_10_11_12_20_21_22);
      chk("gap_last", last_win, 72'h12_13_14_22_23_24_32_33_34);
      chk("gap_count", 72'(win_cnt), 72'd6);
      chk("gap_done", 72'(done_cnt), 72'd1);

      // Two frames back to back, second offset by 0x80
      clear_counts();
      send_pixels(0, W*H, 1'b1, 1'b0, 1'b0);
      win_cnt = 0;
      send_pixels(8'h80, W*H, 1'b1, 1'b0, 1'b0);
      chk("b2b_f2_first", first_win, 72'h80_81_82_90_91_92_A0_A1_A2);
      chk("b2b_f2_last", last_win, 72'h92_93_94_A2_A3_A4_B2_B3_B4);
      chk("b2b_f2_count", 72'(win_cnt), 72'd6);
      chk("b2b_done", 72'(done_cnt), 72'd2);

      // sof lands where pixel (1,3) would be: old frame abandoned
      clear_counts();
      send_pixels(0, W + 3, 1'b1, 1'b0, 1'b0);
      send_pixels(0, W*H, 1'b1, 1'b0, 1'b0);
      chk("abort_first", first_win, 72'h00_01_02_10_11_12_20_21_22);
      chk("abort_count", 72'(win_cnt), 72'd6);
      chk("abort_done", 72'(done_cnt), 72'd1);

      // Reset together with a valid pixel at (2,3), then a frame without sof
      clear_counts();
      send_pixels(0, 2*W + 3, 1'b1, 1'b0, 1'b0);
      win_cnt = 0;
      step(1'b1, 1'b0, 8'h23, 1'b1);
      chk("rst_valid", 72'(pixels_out_valid), 72'd0);
      send_pixels(0, W*H, 1'b0, 1'b1, 1'b0);
      chk("rst_first", first_win, 72'h00_01_02_10_11_12_20_21_22);
      chk("rst_last", last_win, 72'h12_13_14_22_23_24_32_33_34);
      chk("rst_count", 72'(win_cnt), 72'd6);
      chk("rst_done", 72'(done_cnt), 72'd1);

      // Reset on an otherwise idle line, then a dropped pixel under reset
      clear_counts();
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'h55, 1'b1);
      send_pixels(0, W*H, 1'b0, 1'b0, 1'b1);
      chk("drop_count", 72'(win_cnt), 72'd6);
      chk("drop_done", 72'(done_cnt), 72'd1);

      // Randomized frames: random values, gaps, optional sof and random aborts
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 3) == 0)
            send_pixels(0, $urandom_range(1, W*H - 1), 1'b1, 1'b1, 1'b1);
         clear_counts();
         send_pixels(0, W*H, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         chk("rand_count", 72'(win_cnt), 72'd6);
         chk("rand_done", 72'(done_cnt), 72'd1);
      end

      step(1'b0, 1'b0, 8'h00, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
